round_key_reader: RTL and testbench
===================================

// Module: round_key_reader
// PURPOSE
//  Reader side of the key-expansion RAM: once key expansion has finished, walks the RAM and delivers
//  128-bit round keys to the AES round datapath over a valid/ready interface.
//  Supports encrypt order (round 0..Nr) and decrypt order (Nr..0). Round key r = {word[2r], word[2r+1]}.
// PARAMETERS
//  ADDR_W  5   key RAM word-address width (32 x 64-bit words)
//  WORD_W  64  key RAM word width; rk is 2*WORD_W
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-low reset
//  key_mode   in   2       0:AES-128 (Nr=10), 1:AES-192 (Nr=12), 2:AES-256 (Nr=14); 3 treated as 2
//  key_ready  in   1       expansion complete; RAM contents valid
//  start      in   1       1-cycle pulse: begin a round-key sequence
//  decrypt    in   1       sampled with start; 1 = descending order
//  busy       out  1       sequence in progress
//  rd         out  1       RAM read strobe
//  rd_addr    out  ADDR_W  RAM read address
//  rd_data    in   WORD_W  RAM read data, valid exactly 1 cycle after rd
//  rk_valid   out  1       rk/rk_round/rk_last valid
//  rk_ready   in   1       consumer accepts when rk_valid & rk_ready
//  rk         out  2*WORD_W round key, {word[2r], word[2r+1]}
//  rk_round   out  4       round index r of rk
//  rk_last    out  1       rk is the final key of the sequence
// BEHAVIOUR
//  Reset (reset==0 at clk edge): every output 0; FSM to IDLE; any sequence is discarded.
//  Nr = 10/12/14 from key_mode, sampled at start and held for the sequence.
//  start accepted only in IDLE with key_ready=1; otherwise ignored (no state change, busy stays 0).
//  On accept: r = decrypt ? Nr : 0; busy=1 the next cycle.
//  FSM: IDLE -> RD_HI (rd=1, rd_addr=2r) -> RD_LO (rd=1, rd_addr=2r+1; hi <= rd_data)
//   -> CAP (rk <= {hi, rd_data}; rk_valid <= 1) -> OUT (hold rk stable until rk_ready).
//  OUT + handshake: rk_last ? IDLE (busy=0, rk_valid=0) : step r (+1 enc / -1 dec) -> RD_HI.
//  Latency: start to rk_valid = 4 cycles; rk_last=1 when r==Nr (enc) or r==0 (dec).
//  rk, rk_round, rk_last must not change while rk_valid=1 and rk_ready=0.
//  rd is 0 in IDLE/OUT (base build); rd_addr holds its last value when rd=0.
//  key_ready falling in any state other than IDLE: abort to IDLE next cycle, rk_valid=0, busy=0,
//   no further rd; a pending key is dropped, never delivered.
//  start while busy: ignored. Address arithmetic 5-bit, max 2*14+1=29; never wraps.
// CONFIGURATION
//  RKR_PREFETCH_EN defined: 2-entry output buffer; fetch of key r+1 overlaps presentation of key r.
//   With rk_ready held 1, keys issue one per 2 cycles after the first; buffer-full stalls rd.
//   Abort/reset flush both entries; ordering and rk_last unchanged.
//  Undefined: single holding register as above; at most one key per 4 cycles.
// STRUCTURE
//  Package aes_key_pkg: key_mode encodings, NR_128/NR_192/NR_256 constants, FSM state
//   encodings (IDLE, RD_HI, RD_LO, CAP, OUT), function nr_of(key_mode).
//  Sub-module rk_buf (2-entry FIFO of {rk, rk_round, rk_last}), instantiated only under
//   RKR_PREFETCH_EN; base build needs no sub-module.
// TESTING
//  Bench models RAM (1-cycle read) preloaded word[i] = {32'(i), ~32'(i)}.
//  1. mode0, enc, rk_ready=1 -> 11 keys, rk_round 0..10, key0 = {word0,word1}, rk_last only on 10.
//  2. mode2, dec -> 15 keys rk_round 14..0, first rk = {word28,word29}, rd_addr never > 29.
//  3. mode1, enc, rk_ready toggled randomly -> 13 keys, rk stable while stalled, no gaps or dups.
//  4. start with key_ready=0 -> busy stays 0, no rd; start while busy -> ignored.
//  5. key_ready dropped after round 3 handshake -> IDLE next cycle, rk_valid=0, no more keys.
//  6. reset=0 mid-sequence -> all outputs 0 next edge; new start after release restarts at round 0.

Source files
------------

// File: rtl/aes_key_pkg.sv
// Shared encodings for the key-expansion RAM reader: key sizes, round counts
// and reader FSM states.
package aes_key_pkg;

    typedef enum logic [1:0] {
        KEY_MODE_128     = 2'd0,
        KEY_MODE_192     = 2'd1,
        KEY_MODE_256     = 2'd2,
        KEY_MODE_256_ALT = 2'd3
    } key_mode_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        CAP   = 3'd3,
        OUT   = 3'd4
    } rkr_state_e;

    // Encoding 3 is reserved and behaves like AES-256.
    function automatic logic [3:0] nr_of(input logic [1:0] key_mode);
        case (key_mode)
            KEY_MODE_128: return NR_128;
            KEY_MODE_192: return NR_192;
            default:      return NR_256;
        endcase
    endfunction

endpackage

// File: rtl/rk_buf.sv
// Two-entry FIFO of {rk, rk_round, rk_last} used by the prefetching reader.
// The writer guarantees it never pushes into a full buffer.
module rk_buf #(
    parameter int DW = 133
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count_q;
    logic          do_push;
    logic          do_pop;

    always_comb begin
        do_push = push && (count_q != 2'd2);
        do_pop  = pop && (count_q != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0]  <= '0;
            mem[1]  <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (count_q != 2'd0);
    assign count = count_q;

endmodule

// File: rtl/round_key_reader.sv
// Walks the key-expansion RAM and streams 128-bit round keys (encrypt or decrypt order).
// Build option RKR_PREFETCH_EN: overlap fetch of the next key with presentation of the current one.
//
// state | meaning
// IDLE  | waiting for start with key_ready
// RD_HI | reading word 2r
// RD_LO | reading word 2r+1, capturing the high word
// CAP   | assembling rk (prefetch: waiting for buffer room / last capture)
// OUT   | presenting rk until accepted (prefetch: draining the buffer)
module round_key_reader
    import aes_key_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          key_mode,
    input  logic                key_ready,
    input  logic                start,
    input  logic                decrypt,
    output logic                busy,
    output logic                rd,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [WORD_W-1:0]   rd_data,
    output logic                rk_valid,
    input  logic                rk_ready,
    output logic [2*WORD_W-1:0] rk,
    output logic [3:0]          rk_round,
    output logic                rk_last
);

    rkr_state_e          state_q, state_d;
    logic [3:0]          round_q, round_d;
    logic [3:0]          nr_q, nr_d;
    logic                dec_q, dec_d;
    logic [WORD_W-1:0]   hi_q, hi_d;
    logic                busy_d, rd_d;
    logic [ADDR_W-1:0]   rd_addr_d;
    logic                accept, abort, last_now;
    logic [3:0]          round_step;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [3:0] r, input logic lo);
        return ADDR_W'({r, lo});
    endfunction

    assign accept     = (state_q == IDLE) && start && key_ready;
    assign abort      = (state_q != IDLE) && !key_ready;
    assign last_now   = dec_q ? (round_q == 4'd0) : (round_q == nr_q);
    assign round_step = dec_q ? (round_q - 4'd1) : (round_q + 4'd1);

`ifdef RKR_PREFETCH_EN
    logic                cap_pend_q, cap_pend_d;
    logic [3:0]          cap_round_q, cap_round_d;
    logic                cap_last_q, cap_last_d;
    logic                done_q, done_d;
    logic                buf_push, buf_pop, buf_flush, buf_valid;
    logic [1:0]          buf_count, occ_next;
    logic [2*WORD_W+4:0] buf_head;

    // Low word of a key arrives the cycle after RD_LO and is pushed directly.
    assign buf_push = cap_pend_q;
    assign buf_pop  = buf_valid && rk_ready;
    assign occ_next = buf_count + 2'(buf_push) - 2'(buf_pop);

    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        nr_d        = nr_q;
        dec_d       = dec_q;
        hi_d        = hi_q;
        rd_d        = 1'b0;
        rd_addr_d   = rd_addr;
        cap_pend_d  = 1'b0;
        cap_round_d = cap_round_q;
        cap_last_d  = cap_last_q;
        done_d      = done_q;
        buf_flush   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    nr_d      = nr_of(key_mode);
                    dec_d     = decrypt;
                    round_d   = decrypt ? nr_of(key_mode) : 4'd0;
                    done_d    = 1'b0;
                    state_d   = RD_HI;
                    rd_d      = 1'b1;
                    rd_addr_d = word_addr(round_d, 1'b0);
                end
            end
            RD_HI: begin
                state_d   = RD_LO;
                rd_d      = 1'b1;
                rd_addr_d = word_addr(round_q, 1'b1);
            end
            RD_LO: begin
                hi_d        = rd_data;
                cap_pend_d  = 1'b1;
                cap_round_d = round_q;
                cap_last_d  = last_now;
                if (last_now) begin
                    done_d  = 1'b1;
                    state_d = CAP;
                end else begin
                    round_d = round_step;
                    // Two keys will land before any further pop is guaranteed.
                    if (occ_next == 2'd0) begin
                        state_d   = RD_HI;
                        rd_d      = 1'b1;
                        rd_addr_d = word_addr(round_d, 1'b0);
                    end else begin
                        state_d = CAP;
                    end
                end
            end
            CAP: begin
                if (done_q) begin
                    state_d = OUT;
                end else if (occ_next <= 2'd1) begin
                    state_d   = RD_HI;
                    rd_d      = 1'b1;
                    rd_addr_d = word_addr(round_q, 1'b0);
                end
            end
            OUT: begin
                if (buf_pop && rk_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d    = IDLE;
            rd_d       = 1'b0;
            rd_addr_d  = rd_addr;
            cap_pend_d = 1'b0;
            done_d     = 1'b0;
            buf_flush  = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            nr_q        <= '0;
            dec_q       <= 1'b0;
            hi_q        <= '0;
            cap_pend_q  <= 1'b0;
            cap_round_q <= '0;
            cap_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy        <= 1'b0;
            rd          <= 1'b0;
            rd_addr     <= '0;
        end else begin
            state_q     <= state_d;
            round_q     <= round_d;
            nr_q        <= nr_d;
            dec_q       <= dec_d;
            hi_q        <= hi_d;
            cap_pend_q  <= cap_pend_d;
            cap_round_q <= cap_round_d;
            cap_last_q  <= cap_last_d;
            done_q      <= done_d;
            busy        <= busy_d;
            rd          <= rd_d;
            rd_addr     <= rd_addr_d;
        end
    end

    rk_buf #(
        .DW(2*WORD_W+5)
    ) u_rk_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (buf_flush),
        .push      (buf_push),
        .push_data ({hi_q, rd_data, cap_round_q, cap_last_q}),
        .pop       (buf_pop),
        .head      (buf_head),
        .valid     (buf_valid),
        .count     (buf_count)
    );

    assign {rk, rk_round, rk_last} = buf_head;
    assign rk_valid                = buf_valid;

`else
    logic                rk_valid_d;
    logic [2*WORD_W-1:0] rk_d;
    logic [3:0]          rk_round_d;
    logic                rk_last_d;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        nr_d       = nr_q;
        dec_d      = dec_q;
        hi_d       = hi_q;
        rd_d       = 1'b0;
        rd_addr_d  = rd_addr;
        rk_valid_d = rk_valid;
        rk_d       = rk;
        rk_round_d = rk_round;
        rk_last_d  = rk_last;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    nr_d      = nr_of(key_mode);
                    dec_d     = decrypt;
                    round_d   = decrypt ? nr_of(key_mode) : 4'd0;
                    state_d   = RD_HI;
                    rd_d      = 1'b1;
                    rd_addr_d = word_addr(round_d, 1'b0);
                end
            end
            RD_HI: begin
                state_d   = RD_LO;
                rd_d      = 1'b1;
                rd_addr_d = word_addr(round_q, 1'b1);
            end
            RD_LO: begin
                hi_d    = rd_data;
                state_d = CAP;
            end
            CAP: begin
                rk_d       = {hi_q, rd_data};
                rk_round_d = round_q;
                rk_last_d  = last_now;
                rk_valid_d = 1'b1;
                state_d    = OUT;
            end
            OUT: begin
                if (rk_ready) begin
                    rk_valid_d = 1'b0;
                    if (rk_last) begin
                        state_d = IDLE;
                    end else begin
                        round_d   = round_step;
                        state_d   = RD_HI;
                        rd_d      = 1'b1;
                        rd_addr_d = word_addr(round_d, 1'b0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Losing key_ready invalidates the RAM, so any held key is dropped too.
        if (abort) begin
            state_d    = IDLE;
            rd_d       = 1'b0;
            rd_addr_d  = rd_addr;
            rk_valid_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            round_q  <= '0;
            nr_q     <= '0;
            dec_q    <= 1'b0;
            hi_q     <= '0;
            busy     <= 1'b0;
            rd       <= 1'b0;
            rd_addr  <= '0;
            rk_valid <= 1'b0;
            rk       <= '0;
            rk_round <= '0;
            rk_last  <= 1'b0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            nr_q     <= nr_d;
            dec_q    <= dec_d;
            hi_q     <= hi_d;
            busy     <= busy_d;
            rd       <= rd_d;
            rd_addr  <= rd_addr_d;
            rk_valid <= rk_valid_d;
            rk       <= rk_d;
            rk_round <= rk_round_d;
            rk_last  <= rk_last_d;
        end
    end
`endif

endmodule

// File: tb/tb_round_key_reader.sv
// Scoreboard bench for round_key_reader: a 1-cycle RAM model, directed sequences,
// and a negedge monitor that checks every accepted key and stall stability.
module tb_round_key_reader;

    localparam int ADDR_W = 5;
    localparam int WORD_W = 64;

    typedef struct {
        logic [127:0] rk;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [1:0]          key_mode = 2'd0;
    logic                key_ready = 1'b0;
    logic                start = 1'b0;
    logic                decrypt = 1'b0;
    logic                busy;
    logic                rd;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_W-1:0]   rd_data = '0;
    logic                rk_valid;
    logic                rk_ready = 1'b0;
    logic [2*WORD_W-1:0] rk;
    logic [3:0]          rk_round;
    logic                rk_last;

    int           passed = 0;
    int           total = 0;
    exp_t         sb[$];
    int           n_keys = 0;
    int           rd_count = 0;
    int           ready_mode = 0;
    logic [4:0]   max_addr = '0;
    logic [127:0] first_rk = '0;
    logic         stalled_prev = 1'b0;
    logic [127:0] prev_rk = '0;
    logic [3:0]   prev_round = '0;
    logic         prev_last = 1'b0;

    round_key_reader #(
        .ADDR_W(ADDR_W),
        .WORD_W(WORD_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_mode (key_mode),
        .key_ready(key_ready),
        .start    (start),
        .decrypt  (decrypt),
        .busy     (busy),
        .rd       (rd),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk       (rk),
        .rk_round (rk_round),
        .rk_last  (rk_last)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] word_of(input int i);
        logic [31:0] v;
        v = 32'(i);
        return {v, ~v};
    endfunction

    always @(posedge clk) begin
        if (rd) rd_data <= word_of(int'(rd_addr));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: consumes one expected key per handshake, checks holds while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (rd) begin
            rd_count++;
            if (rd_addr > max_addr) max_addr = rd_addr;
        end
        if (stalled_prev && reset && key_ready) begin
            check("stall_valid", 128'(rk_valid), 128'(1));
            check("stall_rk", rk, prev_rk);
            check("stall_tag", {rk_round, rk_last}, {prev_round, prev_last});
        end
        stalled_prev = reset && key_ready && rk_valid && !rk_ready;
        prev_rk      = rk;
        prev_round   = rk_round;
        prev_last    = rk_last;
        if (reset && rk_valid && rk_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_key: got round %0d, expected no key", rk_round);
            end else begin
                e = sb.pop_front();
                check("rk", rk, e.rk);
                check("rk_round", 128'(rk_round), 128'(e.round));
                check("rk_last", 128'(rk_last), 128'(e.last));
            end
            if (n_keys == 0) first_rk = rk;
            n_keys++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0:       rk_ready = 1'b1;
                1:       rk_ready = 1'($urandom_range(0, 1));
                default: rk_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_expected(input int mode, input bit dec, input int count);
        int nr;
        int r;
        nr = (mode == 0) ? 10 : (mode == 1) ? 12 : 14;
        for (int i = 0; i <= nr && i < count; i++) begin
            r = dec ? nr - i : i;
            sb.push_back('{rk: {word_of(2*r), word_of(2*r+1)}, round: 4'(r), last: (i == nr)});
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 500) begin
            tick();
            n++;
        end
        check(name, 128'(busy), 128'(0));
    endtask

    task automatic run_seq(input int mode, input bit dec, input int exp_keys, input bit chk_lat);
        int lat;
        push_expected(mode, dec, 99);
        n_keys   = 0;
        max_addr = '0;
        key_mode = 2'(mode);
        decrypt  = dec;
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (chk_lat) begin
            lat = 1;
            while (!rk_valid && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("latency", 128'(lat), 128'(4));
        end
        wait_idle("seq_done");
        check("sb_empty", 128'(sb.size()), 128'(0));
        check("key_count", 128'(n_keys), 128'(exp_keys));
    endtask

    initial begin
        int rc;
        bit found;
        repeat (3) tick();
        check("rst_ctrl", 128'({busy, rd, rd_addr, rk_valid, rk_round, rk_last}), 128'(0));
        check("rst_rk", rk, 128'(0));
        reset     = 1'b1;
        key_ready = 1'b1;
        tick();

        // 1: AES-128 encrypt
        ready_mode = 0;
        run_seq(0, 1'b0, 11, 1'b1);
        check("t1_first", first_rk, {64'h00000000_FFFFFFFF, 64'h00000001_FFFFFFFE});

        // 2: AES-256 decrypt
        run_seq(2, 1'b1, 15, 1'b0);
        check("t2_first", first_rk, {64'h0000001C_FFFFFFE3, 64'h0000001D_FFFFFFE2});
        check("t2_max_addr", 128'(max_addr), 128'(29));

        // 3: AES-192 encrypt with random backpressure; mode 3 behaves as AES-256
        ready_mode = 1;
        run_seq(1, 1'b0, 13, 1'b0);
        run_seq(3, 1'b0, 15, 1'b0);
        ready_mode = 0;
        tick();

        // 4: start without key_ready, then start while busy
        key_ready = 1'b0;
        rc = rd_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("t4_nokey_busy", 128'(busy), 128'(0));
        check("t4_nokey_rd", 128'(rd_count), 128'(rc));
        key_ready = 1'b1;
        tick();
        push_expected(0, 1'b0, 99);
        n_keys   = 0;
        key_mode = 2'd0;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        key_mode = 2'd2;
        decrypt  = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("t4_busy_done");
        check("t4_sb_empty", 128'(sb.size()), 128'(0));
        check("t4_key_count", 128'(n_keys), 128'(11));
        repeat (3) tick();
        check("t4_stay_idle", 128'(busy), 128'(0));

        // 5: key_ready drops right after the round-3 handshake
        push_expected(0, 1'b0, 4);
        n_keys   = 0;
        key_mode = 2'd0;
        decrypt  = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (rk_valid && rk_ready && rk_round == 4'd3) found = 1'b1;
        end
        check("t5_round3_seen", 128'(found), 128'(1));
        @(posedge clk);
        #2;
        key_ready = 1'b0;
        @(posedge clk);
        #1;
        check("t5_abort", 128'({busy, rk_valid, rd}), 128'(0));
        rc = rd_count;
        repeat (10) tick();
        check("t5_key_count", 128'(n_keys), 128'(4));
        check("t5_sb_empty", 128'(sb.size()), 128'(0));
        check("t5_no_rd", 128'(rd_count), 128'(rc));
        key_ready = 1'b1;
        tick();

        // 6: reset while a key is held, then restart from round 0
        ready_mode = 2;
        key_mode   = 2'd1;
        decrypt    = 1'b0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check("t6_held", 128'(rk_valid), 128'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_ctrl", 128'({busy, rd, rd_addr, rk_valid, rk_round, rk_last}), 128'(0));
        check("t6_rst_rk", rk, 128'(0));
        tick();
        reset      = 1'b1;
        ready_mode = 0;
        tick();
        run_seq(0, 1'b0, 11, 1'b1);
        check("t6_first", first_rk, {64'h00000000_FFFFFFFF, 64'h00000001_FFFFFFFE});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
